// File: rtl/dec10b8b_stage.sv
// 8b/10b decoder stage: turns one 10-bit symbol per cycle back into {K, HGFEDCBA},
// tracks running disparity and flags code and disparity violations. Fixed 1-cycle latency.
module dec10b8b_stage #(
    parameter int unsigned DISP_CHECK = 1,
    parameter logic        RESET_RD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pushin,
    input  logic [9:0] datain,
    input  logic       startin,
    output logic       pushout,
    output logic [8:0] dataout,
    output logic       startout,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd
);

    logic       pushout_q, startout_q, code_err_q, disp_err_q, rd_q;
    logic [8:0] dataout_q;
    logic [8:0] dataout_d;
    logic       code_err_d, disp_err_d, rd_d;

    logic [5:0] s6;
    logic [3:0] f4, f4n;
    logic [4:0] x5;
    logic [2:0] y3, ones6, ones4;
    logic       v6, v4, k28, a7, p7, k28_ok, k_flag;
    logic       rd_in, rd_mid, de6, de4;
    logic       alt_needed, kx7;

    // Sub-blocks rearranged so literals read in transmission order: abcdei and fghj.
    assign s6 = {datain[0], datain[1], datain[2], datain[3], datain[4], datain[5]};
    assign f4 = {datain[6], datain[7], datain[8], datain[9]};
    // K28 after 110000 carries the 4b in complement sense; fold it back to one table.
    assign f4n = (k28 && s6 == 6'b110000) ? ~f4 : f4;

    always_comb begin
        v6  = 1'b1;
        k28 = 1'b0;
        x5  = 5'd0;
        case (s6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110:            x5 = 5'd28;
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            6'b001111, 6'b110000: begin
                x5  = 5'd28;
                k28 = 1'b1;
            end
            default: v6 = 1'b0;
        endcase
    end

    always_comb begin
        v4 = 1'b1;
        a7 = 1'b0;
        p7 = 1'b0;
        y3 = 3'd0;
        case (f4n)
            4'b1011, 4'b0100: y3 = 3'd0;
            4'b1001:          y3 = 3'd1;
            4'b0101:          y3 = 3'd2;
            4'b1100, 4'b0011: y3 = 3'd3;
            4'b1101, 4'b0010: y3 = 3'd4;
            4'b1010:          y3 = 3'd5;
            4'b0110:          y3 = 3'd6;
            4'b1110, 4'b0001: begin
                y3 = 3'd7;
                p7 = 1'b1;
            end
            4'b0111, 4'b1000: begin
                y3 = 3'd7;
                a7 = 1'b1;
            end
            default: v4 = 1'b0;
        endcase
    end

    assign k28_ok = (f4n == 4'b0100) || (f4n == 4'b1001) || (f4n == 4'b0101) ||
                    (f4n == 4'b0011) || (f4n == 4'b0010) || (f4n == 4'b1010) ||
                    (f4n == 4'b0110) || (f4n == 4'b1000);

    assign ones6 = 3'($countones(s6));
    assign ones4 = 3'($countones(f4));
    assign rd_in = startin ? RESET_RD : rd_q;

    always_comb begin
        if (ones6 > 3'd3 || s6 == 6'b000111) begin
            rd_mid = 1'b1;
        end else if (ones6 < 3'd3 || s6 == 6'b111000) begin
            rd_mid = 1'b0;
        end else begin
            rd_mid = rd_in;
        end
        if (ones4 > 3'd2 || f4 == 4'b0011) begin
            rd_d = 1'b1;
        end else if (ones4 < 3'd2 || f4 == 4'b1100) begin
            rd_d = 1'b0;
        end else begin
            rd_d = rd_mid;
        end
    end

    assign de6 = (ones6 < 3'd2) || (ones6 > 3'd4) ||
                 (ones6 == 3'd4 && rd_in) || (ones6 == 3'd2 && !rd_in) ||
                 (s6 == 6'b000111 && !rd_in) || (s6 == 6'b111000 && rd_in);
    assign de4 = (ones4 == 3'd0) || (ones4 == 3'd4) ||
                 (ones4 == 3'd3 && rd_mid) || (ones4 == 3'd1 && !rd_mid) ||
                 (f4 == 4'b0011 && !rd_mid) || (f4 == 4'b1100 && rd_mid);

    // A7 is mandatory exactly where P7 would create a run of five.
    assign alt_needed = ((x5 == 5'd17 || x5 == 5'd18 || x5 == 5'd20) && !rd_mid) ||
                        ((x5 == 5'd11 || x5 == 5'd13 || x5 == 5'd14) && rd_mid);
    assign kx7 = (x5 == 5'd23) || (x5 == 5'd27) || (x5 == 5'd29) || (x5 == 5'd30);

    always_comb begin
        k_flag     = 1'b0;
        code_err_d = !v6 || !v4;
        if (k28) begin
            k_flag = 1'b1;
            if (!k28_ok) code_err_d = 1'b1;
        end else if (a7) begin
            if (kx7) k_flag = 1'b1;
            else if (!alt_needed) code_err_d = 1'b1;
        end else if (p7 && alt_needed) begin
            code_err_d = 1'b1;
        end
        dataout_d  = code_err_d ? 9'h000 : {k_flag, y3, x5};
        disp_err_d = (DISP_CHECK != 0) && (de6 || de4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pushout_q  <= 1'b0;
            dataout_q  <= 9'h000;
            startout_q <= 1'b0;
            code_err_q <= 1'b0;
            disp_err_q <= 1'b0;
            rd_q       <= RESET_RD;
        end else begin
            pushout_q <= pushin;
            if (pushin) begin
                dataout_q  <= dataout_d;
                startout_q <= startin;
                code_err_q <= code_err_d;
                disp_err_q <= disp_err_d;
                rd_q       <= rd_d;
            end
        end
    end

    assign pushout  = pushout_q;
    assign dataout  = dataout_q;
    assign startout = startout_q;
    assign code_err = code_err_q;
    assign disp_err = disp_err_q;
    assign rd       = rd_q;

endmodule

// File: tb/tb_dec10b8b_stage.sv
// Bench for dec10b8b_stage: hand-computed directed symbols, then an encoded stream
// produced by a small reference 8b/10b encoder, with a reset pulse mid-stream.
module tb_dec10b8b_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pushin = 1'b0;
    logic       startin = 1'b0;
    logic [9:0] datain = 10'h000;
    logic       pushout, startout, code_err, disp_err, rd;
    logic [8:0] dataout;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    dec10b8b_stage #(
        .DISP_CHECK(1),
        .RESET_RD  (1'b0)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .pushin  (pushin),
        .datain  (datain),
        .startin (startin),
        .pushout (pushout),
        .dataout (dataout),
        .startout(startout),
        .code_err(code_err),
        .disp_err(disp_err),
        .rd      (rd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference encoder: returns {rd_after, symbol}; symbol bit order matches datain.
    function automatic logic [10:0] enc(input logic [8:0] v, input logic rd_cur);
        logic [4:0] x;
        logic [2:0] y;
        logic       k, rdm, use_a7;
        logic [5:0] c6, s6;
        logic [3:0] c4, f4;
        x  = v[4:0];
        y  = v[7:5];
        k  = v[8];
        c6 = (k && x == 5'd28) ? 6'b001111 : T6[x];
        s6 = (rd_cur && ($countones(c6) != 3 || c6 == 6'b111000)) ? ~c6 : c6;
        rdm = rd_cur ^ ($countones(c6) != 3);
        use_a7 = (y == 3'd7) && (k || (!rdm && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                 (rdm && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        c4 = use_a7 ? 4'b0111 : T4[y];
        if ($countones(c4) != 2 || c4 == 4'b1100) f4 = rdm ? ~c4 : c4;
        else f4 = (k && x == 5'd28 && !rdm) ? ~c4 : c4;
        enc = {rdm ^ ($countones(c4) != 2),
               f4[0], f4[1], f4[2], f4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        pushin  = 1'b0;
        startin = 1'b0;
        datain  = 10'h000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [9:0] sym, input logic st);
        @(negedge clk);
        pushin  = 1'b1;
        datain  = sym;
        startin = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        pushin  = 1'b0;
        startin = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic st, input logic ce, input logic de,
                              input logic r, input logic [8:0] d);
        check_val(tag, {18'd0, pushout, startout, code_err, disp_err, rd, dataout},
                  {18'd0, 1'b1, st, ce, de, r, d});
    endtask

    initial begin
        logic [8:0]  v;
        logic [10:0] e;
        logic        erd, st;
        int          r;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("reset_state", {18'd0, pushout, startout, code_err, disp_err, rd, dataout},
                  32'd0);

        send(10'h17C, 1'b0);
        expect_out("k285_rdneg", 1'b0, 1'b0, 1'b0, 1'b1, 9'h1BC);
        send(10'h283, 1'b0);
        expect_out("k285_rdpos", 1'b0, 1'b0, 1'b0, 1'b0, 9'h1BC);
        idle();
        check_val("idle_hold", {21'd0, pushout, rd, dataout}, {21'd0, 1'b0, 1'b0, 9'h1BC});

        do_reset();
        send(10'h17C, 1'b0);
        expect_out("k285_first", 1'b0, 1'b0, 1'b0, 1'b1, 9'h1BC);
        send(10'h17C, 1'b0);
        expect_out("k285_repeat", 1'b0, 1'b0, 1'b1, 1'b1, 9'h1BC);

        do_reset();
        send(10'h0B9, 1'b0);
        expect_out("d00_rdneg", 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        send(10'h000, 1'b0);
        check_val("all_zero_sym", {22'd0, code_err, dataout}, {22'd0, 1'b1, 9'h000});

        do_reset();
        send(10'h17C, 1'b0);
        send(10'h17C, 1'b1);
        expect_out("start_resync", 1'b1, 1'b0, 1'b0, 1'b1, 9'h1BC);

        do_reset();
        send(10'h3B1, 1'b0);
        expect_out("d177_a7", 1'b0, 1'b0, 1'b0, 1'b1, 9'h0F1);
        do_reset();
        send(10'h057, 1'b0);
        expect_out("k237", 1'b0, 1'b0, 1'b0, 1'b0, 9'h1F7);
        do_reset();
        send(10'h1F1, 1'b0);
        expect_out("d177_p7_bad", 1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
        do_reset();
        send(10'h23C, 1'b0);
        expect_out("k28_bad_4b", 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);

        do_reset();
        erd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v = 9'($urandom);
            if (v[8]) begin
                r = int'($urandom_range(0, 11));
                if (r < 8) v = {1'b1, 3'(r), 5'd28};
                else if (r == 8) v = {1'b1, 3'd7, 5'd23};
                else if (r == 9) v = {1'b1, 3'd7, 5'd27};
                else if (r == 10) v = {1'b1, 3'd7, 5'd29};
                else v = {1'b1, 3'd7, 5'd30};
            end
            if (i == 150) begin
                e = enc(v, erd);
                @(negedge clk);
                reset  = 1'b1;
                pushin = 1'b1;
                datain = e[9:0];
                @(posedge clk);
                #1;
                check_val("reset_midstream", {30'd0, pushout, rd}, 32'd0);
                @(negedge clk);
                reset  = 1'b0;
                pushin = 1'b0;
                erd    = 1'b0;
            end else begin
                st = ($urandom_range(0, 15) == 0);
                if (st) erd = 1'b0;
                e = enc(v, erd);
                send(e[9:0], st);
                expect_out("stream", st, 1'b0, 1'b0, e[10], v);
                erd = e[10];
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
